// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared definitions for the decode-stage serialization logic.
//   - ser_state_e    : sequencer states (IDLE / DRAIN / NOTIFY)
//   - ALU_LL, ALU_SC : ALU-control codes of the load-linked / store-conditional ops
//   - SYSCALL_OPWORD : full instruction word of SYSCALL
//   - classify_serializing() : decoder helper deriving Serialize/Notify flags
// -----------------------------------------------------------------------------
package id_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_NOTIFY = 2'd2
  } ser_state_e;

  localparam logic [5:0]  ALU_LL         = 6'b101000;
  localparam logic [5:0]  ALU_SC         = 6'b110110;
  localparam logic [31:0] SYSCALL_OPWORD = 32'h0000000C;

  typedef struct packed {
    logic serialize;
    logic notify;
  } ser_class_t;

  // SYSCALL drains and notifies the simulator; LL/SC only drain.
  function automatic ser_class_t classify_serializing(input logic [31:0] instr,
                                                      input logic [5:0]  alu_ctrl);
    ser_class_t c;
    c.serialize = 1'b0;
    c.notify    = 1'b0;
    if (instr == SYSCALL_OPWORD) begin
      c.serialize = 1'b1;
      c.notify    = 1'b1;
    end else if ((alu_ctrl == ALU_LL) || (alu_ctrl == ALU_SC)) begin
      c.serialize = 1'b1;
      c.notify    = 1'b0;
    end else begin
      c.serialize = 1'b0;
      c.notify    = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/id_drain_counter.sv
// -----------------------------------------------------------------------------
// id_drain_counter
// Loadable down-counter with a zero flag; counts the remaining drain bubbles.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   load_i          : load load_val_i (has priority over decrement)
//   load_val_i      : value to load
//   dec_i           : decrement by one; saturates at zero
//   zero_o          : counter currently equals zero
// -----------------------------------------------------------------------------
module id_drain_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/id_serialize_ctrl.sv
// -----------------------------------------------------------------------------
// id_serialize_ctrl
// ID->EXE issue register plus serialization sequencer. A serializing
// instruction (SYSCALL, LL/SC) is issued with Kill_OUT set, followed by
// DRAIN_CYCLES+1 bubbles; a one-cycle SYS pulse is raised in the last one
// when the instruction asked for it.
// Ports:
//   CLK, RESET (async, active low)
//   Instr_IN / Instr_PC_IN / Payload_IN : instruction in ID and its bundle
//   Serialize_IN, Notify_IN             : decoder classification
//   FWD_REQ_FREEZE                      : load-use stall request
//   EXE_STALL                           : EXE cannot accept, hold everything
//   Instr_OUT / Instr_PC_OUT / Payload_OUT / Valid_OUT / Kill_OUT : to EXE
//   SYS          : registered syscall notification
//   WANT_FREEZE  : combinational, fetch holds the PC
//   Busy         : combinational, sequencer not idle
//   SerCount_OUT : wrapping count of accepted serializing instructions
// -----------------------------------------------------------------------------
module id_serialize_ctrl
  import id_pkg::*;
#(
  parameter int unsigned PAYLOAD_W    = 96,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          Instr_IN,
  input  logic [31:0]          Instr_PC_IN,
  input  logic [PAYLOAD_W-1:0] Payload_IN,
  input  logic                 Serialize_IN,
  input  logic                 Notify_IN,
  input  logic                 FWD_REQ_FREEZE,
  input  logic                 EXE_STALL,
  output logic [31:0]          Instr_OUT,
  output logic [31:0]          Instr_PC_OUT,
  output logic [PAYLOAD_W-1:0] Payload_OUT,
  output logic                 Valid_OUT,
  output logic                 Kill_OUT,
  output logic                 SYS,
  output logic                 WANT_FREEZE,
  output logic                 Busy,
  output logic [CNT_W-1:0]     SerCount_OUT
);

  localparam int unsigned         DW         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]       DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);

  ser_state_e             state_q;
  logic                   notify_q;
  logic                   sys_q;
  logic [31:0]            instr_q;
  logic [31:0]            pc_q;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic                   valid_q;
  logic                   kill_q;
  logic [CNT_W-1:0]       ser_cnt_q;

  logic                   drain_load_s;
  logic                   drain_dec_s;
  logic                   drain_zero_s;
  logic                   want_freeze_s;

  id_drain_counter #(
    .W (DW)
  ) u_drain_counter (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .load_i     (drain_load_s),
    .load_val_i (DRAIN_LOAD),
    .dec_i      (drain_dec_s),
    .zero_o     (drain_zero_s)
  );

  // Counter controls and fetch freeze. A stall freezes fetch and the counter.
  // NOTIFY deliberately drops the freeze so fetch moves past the serializing
  // instruction even if forwarding is asking for a stall.
  always_comb begin
    drain_load_s  = 1'b0;
    drain_dec_s   = 1'b0;
    want_freeze_s = 1'b0;
    if (EXE_STALL) begin
      want_freeze_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          drain_load_s  = Serialize_IN;
          want_freeze_s = Serialize_IN | FWD_REQ_FREEZE;
        end
        ST_DRAIN: begin
          drain_dec_s   = 1'b1;
          want_freeze_s = 1'b1;
        end
        ST_NOTIFY: begin
          want_freeze_s = 1'b0;
        end
        default: begin
          want_freeze_s = 1'b1;
        end
      endcase
    end
  end

  // Sequencer and issue register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      notify_q  <= 1'b0;
      sys_q     <= 1'b0;
      instr_q   <= 32'd0;
      pc_q      <= 32'd0;
      payload_q <= {PAYLOAD_W{1'b0}};
      valid_q   <= 1'b0;
      kill_q    <= 1'b0;
      ser_cnt_q <= {CNT_W{1'b0}};
    end else if (EXE_STALL) begin
      // hold all state
    end else begin
      case (state_q)
        ST_IDLE: begin
          sys_q <= 1'b0;
          if (Serialize_IN) begin
            instr_q   <= Instr_IN;
            pc_q      <= Instr_PC_IN;
            payload_q <= Payload_IN;
            valid_q   <= 1'b1;
            kill_q    <= 1'b1;
            notify_q  <= Notify_IN;
            ser_cnt_q <= ser_cnt_q + CNT_ONE;
            state_q   <= ST_DRAIN;
          end else if (FWD_REQ_FREEZE) begin
            // load-use bubble; PC of the bubble keeps the last issued PC
            instr_q   <= 32'd0;
            payload_q <= {PAYLOAD_W{1'b0}};
            valid_q   <= 1'b0;
            kill_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            instr_q   <= Instr_IN;
            pc_q      <= Instr_PC_IN;
            payload_q <= Payload_IN;
            valid_q   <= 1'b1;
            kill_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          instr_q   <= 32'd0;
          payload_q <= {PAYLOAD_W{1'b0}};
          valid_q   <= 1'b0;
          kill_q    <= 1'b0;
          if (drain_zero_s) begin
            state_q <= ST_NOTIFY;
            sys_q   <= notify_q;
          end else begin
            state_q <= ST_DRAIN;
            sys_q   <= 1'b0;
          end
        end
        ST_NOTIFY: begin
          instr_q   <= 32'd0;
          payload_q <= {PAYLOAD_W{1'b0}};
          valid_q   <= 1'b0;
          kill_q    <= 1'b0;
          sys_q     <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          instr_q   <= 32'd0;
          payload_q <= {PAYLOAD_W{1'b0}};
          valid_q   <= 1'b0;
          kill_q    <= 1'b0;
          sys_q     <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign Instr_OUT    = instr_q;
  assign Instr_PC_OUT = pc_q;
  assign Payload_OUT  = payload_q;
  assign Valid_OUT    = valid_q;
  assign Kill_OUT     = kill_q;
  assign SYS          = sys_q;
  assign SerCount_OUT = ser_cnt_q;
  assign WANT_FREEZE  = want_freeze_s;
  assign Busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_id_serialize_ctrl.sv
// -----------------------------------------------------------------------------
// tb_id_serialize_ctrl
// Scoreboard bench: the driver applies one input vector per cycle, advances a
// reference model that tracks "bubbles still owed" after a serializing
// instruction, and queues the expected outputs; a monitor samples the DUT each
// cycle and compares against the queue head.
// -----------------------------------------------------------------------------
module tb_id_serialize_ctrl;
  import id_pkg::*;

  localparam int PW = 96;
  localparam int DC = 3;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [31:0]   Instr_IN = 32'd0;
  logic [31:0]   Instr_PC_IN = 32'd0;
  logic [PW-1:0] Payload_IN = '0;
  logic          Serialize_IN = 1'b0;
  logic          Notify_IN = 1'b0;
  logic          FWD_REQ_FREEZE = 1'b0;
  logic          EXE_STALL = 1'b0;
  logic [31:0]   Instr_OUT;
  logic [31:0]   Instr_PC_OUT;
  logic [PW-1:0] Payload_OUT;
  logic          Valid_OUT;
  logic          Kill_OUT;
  logic          SYS;
  logic          WANT_FREEZE;
  logic          Busy;
  logic [CW-1:0] SerCount_OUT;

  id_serialize_ctrl #(.PAYLOAD_W(PW), .DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .Instr_IN(Instr_IN), .Instr_PC_IN(Instr_PC_IN),
    .Payload_IN(Payload_IN), .Serialize_IN(Serialize_IN), .Notify_IN(Notify_IN),
    .FWD_REQ_FREEZE(FWD_REQ_FREEZE), .EXE_STALL(EXE_STALL), .Instr_OUT(Instr_OUT),
    .Instr_PC_OUT(Instr_PC_OUT), .Payload_OUT(Payload_OUT), .Valid_OUT(Valid_OUT),
    .Kill_OUT(Kill_OUT), .SYS(SYS), .WANT_FREEZE(WANT_FREEZE), .Busy(Busy),
    .SerCount_OUT(SerCount_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [PW-1:0] pay;
    logic          valid;
    logic          kill;
    logic          sys;
    logic [CW-1:0] cnt;
    logic          wf;
    logic          busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  // reference model state
  logic [31:0]   m_instr = 32'd0;
  logic [31:0]   m_pc = 32'd0;
  logic [PW-1:0] m_pay = '0;
  logic          m_valid = 1'b0;
  logic          m_kill = 1'b0;
  logic          m_sys = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  int            m_owed = 0;   // bubbles still owed after a serializing instr
  logic          m_notif = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and queue what the DUT must show.
  task automatic cycle(input logic rst, input logic ser, input logic ntf, input logic fwd,
                       input logic stall, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [PW-1:0] pay);
    exp_t e;
    @(negedge CLK);
    RESET = rst; Serialize_IN = ser; Notify_IN = ntf; FWD_REQ_FREEZE = fwd;
    EXE_STALL = stall; Instr_IN = ins; Instr_PC_IN = pc; Payload_IN = pay;
    if (!rst) begin
      m_owed = 0;
      e.busy = 1'b0;
      e.wf = stall | ser | fwd;
      m_instr = 32'd0; m_pc = 32'd0; m_pay = '0; m_valid = 1'b0; m_kill = 1'b0;
      m_sys = 1'b0; m_cnt = '0; m_notif = 1'b0;
    end else begin
      e.busy = (m_owed > 0);
      if (stall) e.wf = 1'b1;
      else if (m_owed > 0) e.wf = (m_owed != 1);   // last owed bubble releases fetch
      else e.wf = ser | fwd;
      if (stall) begin
        // nothing moves
      end else if (m_owed > 0) begin
        m_instr = 32'd0; m_pay = '0; m_valid = 1'b0; m_kill = 1'b0;
        m_owed--;
        m_sys = (m_owed == 1) && m_notif;
      end else if (ser) begin
        m_instr = ins; m_pc = pc; m_pay = pay; m_valid = 1'b1; m_kill = 1'b1;
        m_notif = ntf; m_owed = DC + 1; m_cnt = m_cnt + 1'b1; m_sys = 1'b0;
      end else if (fwd) begin
        m_instr = 32'd0; m_pay = '0; m_valid = 1'b0; m_kill = 1'b0; m_sys = 1'b0;
      end else begin
        m_instr = ins; m_pc = pc; m_pay = pay; m_valid = 1'b1; m_kill = 1'b0; m_sys = 1'b0;
      end
    end
    e.instr = m_instr; e.pc = m_pc; e.pay = m_pay; e.valid = m_valid; e.kill = m_kill;
    e.sys = m_sys; e.cnt = m_cnt;
    sb.push_back(e);
    if (!rst) begin
      #1;
      chk("rst_valid", {127'd0, Valid_OUT}, 128'd0);
      chk("rst_sys", {127'd0, SYS}, 128'd0);
      chk("rst_busy", {127'd0, Busy}, 128'd0);
      chk("rst_sercount", {112'd0, SerCount_OUT}, 128'd0);
    end
  endtask

  task automatic plain(input logic fwd);
    cycle(1'b1, 1'b0, 1'b0, fwd, 1'b0, $urandom(), $urandom(),
          {$urandom(), $urandom(), $urandom()});
  endtask

  task automatic serial(input logic [31:0] ins, input logic ntf);
    cycle(1'b1, 1'b1, ntf, 1'b0, 1'b0, ins, $urandom(), {$urandom(), $urandom(), $urandom()});
  endtask

  task automatic stall_cycle();
    cycle(1'b1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 1'b1,
          $urandom(), $urandom(), {$urandom(), $urandom(), $urandom()});
  endtask

  // Monitor: combinational outputs before the edge, registered ones after it.
  initial begin
    exp_t e;
    logic s_wf, s_busy;
    forever begin
      @(negedge CLK);
      #3;
      s_wf = WANT_FREEZE;
      s_busy = Busy;
      @(posedge CLK);
      #1;
      if (!done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: no expected entry queued");
        end else begin
          e = sb.pop_front();
          chk("want_freeze", {127'd0, s_wf}, {127'd0, e.wf});
          chk("busy", {127'd0, s_busy}, {127'd0, e.busy});
          chk("valid", {127'd0, Valid_OUT}, {127'd0, e.valid});
          chk("kill", {127'd0, Kill_OUT}, {127'd0, e.kill});
          chk("sys", {127'd0, SYS}, {127'd0, e.sys});
          chk("instr", {96'd0, Instr_OUT}, {96'd0, e.instr});
          chk("pc", {96'd0, Instr_PC_OUT}, {96'd0, e.pc});
          chk("payload", {32'd0, Payload_OUT}, {32'd0, e.pay});
          chk("sercount", {112'd0, SerCount_OUT}, {112'd0, e.cnt});
        end
      end
    end
  end

  initial begin
    int r;
    // reset
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, '0);
    // plain stream
    repeat (6) plain(1'b0);
    // SYSCALL with notify
    serial(SYSCALL_OPWORD, 1'b1);
    repeat (6) plain(1'b0);
    // SC without notify
    serial($urandom(), 1'b0);
    repeat (6) plain(1'b0);
    // stall during drain with the counter at 1
    serial(SYSCALL_OPWORD, 1'b1);
    plain(1'b0);
    repeat (2) stall_cycle();
    repeat (6) plain(1'b0);
    // load-use bubble in IDLE, then freeze request during NOTIFY
    plain(1'b1);
    plain(1'b0);
    serial(SYSCALL_OPWORD, 1'b1);
    repeat (3) plain(1'b0);
    plain(1'b1);
    repeat (2) plain(1'b0);
    // back-to-back serializing instructions
    serial(SYSCALL_OPWORD, 1'b1);
    repeat (4) plain(1'b0);
    serial($urandom(), 1'b0);
    repeat (5) plain(1'b0);
    // reset mid-drain, then a fresh SYSCALL
    serial(SYSCALL_OPWORD, 1'b1);
    plain(1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, '0);
    serial(SYSCALL_OPWORD, 1'b1);
    repeat (6) plain(1'b0);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12) serial($urandom(), $urandom_range(0, 1));
      else if (r < 27) stall_cycle();
      else if (r < 47) plain(1'b1);
      else if (r < 48) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, '0);
      else plain(1'b0);
    end
    @(negedge CLK);
    done = 1'b1;
    Serialize_IN = 1'b0; FWD_REQ_FREEZE = 1'b0; EXE_STALL = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_leftover: %0d entries never compared", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_serialize_ctrl.md
Name: id_serialize_ctrl

Overview:
Parametrised ID→EXE issue register and serialization sequencer for the decode stage. It replaces the fixed 4-count syscall bubble counter with a configurable-depth FSM that:
- drains the pipeline behind serializing instructions (SYSCALL, LL/SC);
- raises a one-cycle SYS notification only for instructions that need it;
- gates WANT_FREEZE;
- honours a downstream EXE stall.

It sits between the decoder/register-read logic and the EXE pipeline register inputs.

Parameters:
- PAYLOAD_W, 96: width of the decoded control/operand bundle (operands, regs, ALU control, mem flags, shamt).
- DRAIN_CYCLES, 3: bubble cycles inserted after a serializing instruction before notify. Legal range 1..15.
- CNT_W, 16: width of the serialization event counter.

Ports:
- CLK, in, 1: clock.
- RESET, in, 1: asynchronous, active-low reset.
- Instr_IN, in, 32: instruction currently in ID.
- Instr_PC_IN, in, 32: PC of Instr_IN.
- Payload_IN, in, PAYLOAD_W: decoded bundle for Instr_IN.
- Serialize_IN, in, 1: decoder flag; Instr_IN is serializing.
- Notify_IN, in, 1: serializing instruction needs SYS to the simulator (0 for LL/SC).
- FWD_REQ_FREEZE, in, 1: forwarding unit needs a load-use stall.
- EXE_STALL, in, 1: EXE cannot accept; hold everything.
- Instr_OUT, out, 32: registered instruction to EXE.
- Instr_PC_OUT, out, 32: registered PC to EXE.
- Payload_OUT, out, PAYLOAD_W: registered bundle to EXE.
- Valid_OUT, out, 1: Instr_OUT/Payload_OUT are a real instruction.
- Kill_OUT, out, 1: instruction travels for MEM flush only; downstream suppresses register and memory writes.
- SYS, out, 1: registered one-cycle syscall notification.
- WANT_FREEZE, out, 1: combinational; fetch holds PC.
- Busy, out, 1: combinational; FSM not in IDLE.
- SerCount_OUT, out, CNT_W: count of serializing instructions accepted; wraps modulo 2^CNT_W.

Behaviour:
Reset (RESET=0, async):
- State=IDLE; drain counter=0; notify latch=0.
- Every registered output = 0: Instr_OUT, Instr_PC_OUT, Payload_OUT, Valid_OUT, Kill_OUT, SYS, SerCount_OUT.
- Applies mid-drain or mid-notify as well; no residual SYS pulse after release.

States: IDLE, DRAIN, NOTIFY.

Priority, per cycle: EXE_STALL > FSM state > Serialize_IN > FWD_REQ_FREEZE.

EXE_STALL=1 (any state):
- All registers hold, including FSM, counter and SYS.
- WANT_FREEZE=1.

IDLE:
- Serialize_IN=1:
  - Capture Instr_OUT/PC/Payload from the inputs; Valid_OUT=1, Kill_OUT=1.
  - Latch Notify_IN; counter ← DRAIN_CYCLES−1; SerCount_OUT +1; go to DRAIN.
  - WANT_FREEZE=1 this cycle.
- Serialize_IN=0, FWD_REQ_FREEZE=1:
  - Insert a bubble: Valid_OUT=0, Kill_OUT=0, Instr_OUT=0, Payload_OUT=0.
  - Instr_PC_OUT holds. WANT_FREEZE=1.
- Otherwise:
  - Pass the instruction: Valid_OUT=1, Kill_OUT=0. WANT_FREEZE=0.

DRAIN:
- Each cycle: bubble (Valid_OUT=0, Kill_OUT=0, Instr_OUT=0, Payload_OUT=0); WANT_FREEZE=1.
- Counter ≠0: decrement.
- Counter =0: go to NOTIFY; SYS ← notify latch.
- Serialize_IN and FWD_REQ_FREEZE are ignored in this state.

NOTIFY:
- SYS is high for exactly this cycle.
- WANT_FREEZE=0 (inhibit), even if FWD_REQ_FREEZE=1, so fetch advances past the serializing instruction.
- Bubble output.
- Next state IDLE; SYS ← 0.

Latency and sequencing:
- Serializing instruction accepted at edge k.
- Bubbles at edges k+1 … k+DRAIN_CYCLES+1, i.e. DRAIN_CYCLES+1 bubbles.
- SYS high between edges k+DRAIN_CYCLES and k+DRAIN_CYCLES+1.
- The following instruction is evaluated in IDLE from edge k+DRAIN_CYCLES+1.

Other rules:
- Back-to-back serializing instructions: the second is accepted normally from IDLE; no cycles are merged.
- Notify_IN=0: identical timing; SYS stays 0.
- Busy = (state≠IDLE).

Decomposition:
- Shared package id_pkg holds:
  - the state enum (IDLE/DRAIN/NOTIFY);
  - ALU-control constants for LL (6'b101000) and SC (6'b110110);
  - SYSCALL_OPWORD = 32'h0000000C.
- The decoder uses these to derive Serialize_IN/Notify_IN.
- One natural sub-module: id_drain_counter (loadable down-counter with zero flag, width $clog2(DRAIN_CYCLES+1)).

Test Plan:
Default parameters throughout.
1. Plain stream (addi, add, lw); Serialize_IN=0, stalls=0:
   - Valid_OUT=1 each cycle, one-cycle latency, WANT_FREEZE=0, SYS never 1.
2. SYSCALL (Instr_IN=0x0000000C, Serialize_IN=1, Notify_IN=1) at edge k:
   - At k: Instr_OUT=0xC, Kill_OUT=1.
   - Valid_OUT=0 at k+1..k+4; SYS=1 only between k+3 and k+4.
   - WANT_FREEZE=1 through DRAIN, 0 in NOTIFY; SerCount_OUT=1.
3. SC with Notify_IN=0:
   - Same bubble timing as scenario 2; SYS stays 0 throughout.
4. EXE_STALL=1 for 2 cycles during DRAIN (counter=1):
   - Outputs and counter frozen; SYS pulse delayed by exactly 2 cycles; still one cycle wide.
5. FWD_REQ_FREEZE=1 for 1 cycle in IDLE with a normal instruction:
   - One bubble (Valid_OUT=0), WANT_FREEZE=1; the instruction issues on the next edge.
   - FWD_REQ_FREEZE=1 during NOTIFY: WANT_FREEZE=0.
6. RESET pulled low during DRAIN (counter=1):
   - Immediately Valid_OUT=0, SYS=0, Busy=0, SerCount_OUT=0.
   - After release, a new SYSCALL reproduces the timing of scenario 2.
